switch_box_cfg: RTL and testbench



---
 rtl/swbox_pkg.sv | 29 ++
 rtl/swbox_cfg_loader.sv | 107 ++++++++++
 rtl/switch_box_cfg.sv | 79 +++++++
 tb/tb_switch_box_cfg.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/swbox_pkg.sv
// Shared side-select codes, loader state type and entry-field helpers for the
// run-time configurable switch box.
package swbox_pkg;

  localparam int SEL_W     = 3;
  localparam int ENT_MAX_W = 16;

  localparam logic [SEL_W-1:0] SIDE_NONE   = 3'd0;
  localparam logic [SEL_W-1:0] SIDE_TOP    = 3'd1;
  localparam logic [SEL_W-1:0] SIDE_RIGHT  = 3'd2;
  localparam logic [SEL_W-1:0] SIDE_BOTTOM = 3'd3;
  localparam logic [SEL_W-1:0] SIDE_LEFT   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_FULL
  } ld_state_e;

  // Entries are zero-extended to ENT_MAX_W by the caller so one helper serves any IDX_W.
  function automatic logic [SEL_W-1:0] ent_side(input logic [ENT_MAX_W-1:0] e);
    return e[SEL_W-1:0];
  endfunction

  function automatic logic [ENT_MAX_W-1:0] ent_idx(input logic [ENT_MAX_W-1:0] e);
    return e >> SEL_W;
  endfunction

endpackage

// File: rtl/swbox_cfg_loader.sv
// Serial bitstream loader: shadow shift register, bit counter, load FSM,
// commit-time validation and the active configuration bank.
module swbox_cfg_loader
  import swbox_pkg::*;
#(
  parameter int NTB      = 5,
  parameter int NLR      = 4,
  parameter int ENT_W    = 6,
  parameter int N_ENT    = 2*NTB + 2*NLR,
  parameter int TOT_BITS = N_ENT*ENT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_din,
  input  logic                cfg_valid,
  input  logic                cfg_commit,
  input  logic                cfg_abort,
  output logic                cfg_ready,
  output logic                cfg_dout,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [TOT_BITS-1:0] active
);

  localparam int              CNT_W = $clog2(TOT_BITS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOT_BITS - 1);

  ld_state_e           state;
  logic [CNT_W-1:0]    cnt;
  logic [TOT_BITS-1:0] shadow;
  logic [TOT_BITS-1:0] checked;
  logic [N_ENT-1:0]    bad;

  assign cfg_dout = shadow[TOT_BITS-1];

  // The first entry sent sits at the shadow MSB; active keeps entry k at k*ENT_W.
  always_comb begin
    checked = '0;
    bad     = '0;
    for (int k = 0; k < N_ENT; k++) begin
      logic [ENT_W-1:0]     ent;
      logic [SEL_W-1:0]     side;
      logic [ENT_MAX_W-1:0] idx;
      logic                 ok;
      ent  = shadow[TOT_BITS-1-k*ENT_W -: ENT_W];
      side = ent_side(ENT_MAX_W'(ent));
      idx  = ent_idx(ENT_MAX_W'(ent));
      case (side)
        SIDE_NONE:              ok = 1'b1;
        SIDE_TOP, SIDE_BOTTOM:  ok = idx < ENT_MAX_W'(NTB);
        SIDE_RIGHT, SIDE_LEFT:  ok = idx < ENT_MAX_W'(NLR);
        default:                ok = 1'b0;
      endcase
      bad[k]                      = ~ok;
      checked[k*ENT_W +: ENT_W]   = ok ? ent : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shadow    <= '0;
      active    <= '0;
      cfg_ready <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (cfg_abort) begin
        state     <= ST_IDLE;
        cnt       <= '0;
        shadow    <= '0;
        cfg_ready <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: if (cfg_valid) begin
            shadow <= {shadow[TOT_BITS-2:0], cfg_din};
            cnt    <= CNT_W'(1);
            state  <= ST_SHIFT;
          end
          ST_SHIFT: if (cfg_valid) begin
            shadow <= {shadow[TOT_BITS-2:0], cfg_din};
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              state     <= ST_FULL;
              cfg_ready <= 1'b0;
            end
          end
          ST_FULL: if (cfg_commit) begin
            active    <= checked;
            cfg_err   <= |bad;
            cfg_done  <= 1'b1;
            cnt       <= '0;
            state     <= ST_IDLE;
            cfg_ready <= 1'b1;
          end
          default: begin
            state     <= ST_IDLE;
            cfg_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/switch_box_cfg.sv
// Programmable four-sided switch box: every wire can be driven from any wire on
// any side, routing taken from the loader's active configuration.
module switch_box_cfg
  import swbox_pkg::*;
#(
  parameter int NTB      = 5,
  parameter int NLR      = 4,
  parameter int IDX_W    = $clog2((NTB > NLR) ? NTB : NLR),
  parameter int ENT_W    = IDX_W + SEL_W,
  parameter int N_ENT    = 2*NTB + 2*NLR,
  parameter int TOT_BITS = N_ENT*ENT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  inout  wire  [NTB-1:0] wtop,
  inout  wire  [NTB-1:0] wbottom,
  inout  wire  [NLR-1:0] wleft,
  inout  wire  [NLR-1:0] wright,
  input  logic           cfg_din,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic           cfg_commit,
  input  logic           cfg_abort,
  output logic           cfg_dout,
  output logic           cfg_done,
  output logic           cfg_err
);

  localparam int SRC_N = 1 << IDX_W;

  logic [TOT_BITS-1:0] active;
  logic [SRC_N-1:0]    src_top, src_bottom, src_left, src_right;
  logic [N_ENT-1:0]    drv_en, drv_val;

  swbox_cfg_loader #(
    .NTB(NTB), .NLR(NLR), .ENT_W(ENT_W), .N_ENT(N_ENT), .TOT_BITS(TOT_BITS)
  ) u_loader (
    .clk(clk), .rst_n(rst_n),
    .cfg_din(cfg_din), .cfg_valid(cfg_valid), .cfg_commit(cfg_commit), .cfg_abort(cfg_abort),
    .cfg_ready(cfg_ready), .cfg_dout(cfg_dout), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .active(active)
  );

  // Padding to a power of two keeps every index in range; validated entries never reach the pad.
  assign src_top    = SRC_N'(wtop);
  assign src_bottom = SRC_N'(wbottom);
  assign src_left   = SRC_N'(wleft);
  assign src_right  = SRC_N'(wright);

  always_comb begin
    drv_en  = '0;
    drv_val = '0;
    for (int k = 0; k < N_ENT; k++) begin
      logic [SEL_W-1:0] side;
      logic [IDX_W-1:0] idx;
      side = ent_side(ENT_MAX_W'(active[k*ENT_W +: ENT_W]));
      idx  = IDX_W'(ent_idx(ENT_MAX_W'(active[k*ENT_W +: ENT_W])));
      drv_en[k] = (side != SIDE_NONE);
      case (side)
        SIDE_TOP:    drv_val[k] = src_top[idx];
        SIDE_RIGHT:  drv_val[k] = src_right[idx];
        SIDE_BOTTOM: drv_val[k] = src_bottom[idx];
        SIDE_LEFT:   drv_val[k] = src_left[idx];
        default:     drv_val[k] = 1'b0;
      endcase
    end
  end

  // Flat destination order matches the bitstream: top, bottom, left, right.
  for (genvar i = 0; i < NTB; i++) begin : g_tb
    assign wtop[i]    = drv_en[i]       ? drv_val[i]       : 1'bz;
    assign wbottom[i] = drv_en[NTB+i]   ? drv_val[NTB+i]   : 1'bz;
  end
  for (genvar i = 0; i < NLR; i++) begin : g_lr
    assign wleft[i]  = drv_en[2*NTB+i]     ? drv_val[2*NTB+i]     : 1'bz;
    assign wright[i] = drv_en[2*NTB+NLR+i] ? drv_val[2*NTB+NLR+i] : 1'bz;
  end

endmodule

// File: tb/tb_switch_box_cfg.sv
// Directed plus randomized bench for switch_box_cfg, including a two-box chain.
module tb_switch_box_cfg;

  localparam int NTB = 5, NLR = 4, N_ENT = 18, ENT_W = 6, TOT = 108;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_din = 1'b0, cfg_valid = 1'b0, cfg_commit = 1'b0, cfg_abort = 1'b0;
  logic chain_en = 1'b0;
  wire  cfg_ready, cfg_dout, cfg_done, cfg_err;
  wire  b_ready, b_dout, b_done, b_err;
  wire  b_valid  = chain_en & cfg_valid & cfg_ready;
  wire  b_commit = chain_en & cfg_commit;

  wire [NTB-1:0] wtop, wbottom, b_wtop, b_wbottom;
  wire [NLR-1:0] wleft, wright, b_wleft, b_wright;
  wire [N_ENT-1:0] wall = {wright, wleft, wbottom, wtop};

  logic [N_ENT-1:0] tb_en = '0, tb_val = '0;

  for (genvar i = 0; i < NTB; i++) begin : g_dtb
    assign wtop[i]    = tb_en[i]     ? tb_val[i]     : 1'bz;
    assign wbottom[i] = tb_en[NTB+i] ? tb_val[NTB+i] : 1'bz;
  end
  for (genvar i = 0; i < NLR; i++) begin : g_dlr
    assign wleft[i]  = tb_en[2*NTB+i]     ? tb_val[2*NTB+i]     : 1'bz;
    assign wright[i] = tb_en[2*NTB+NLR+i] ? tb_val[2*NTB+NLR+i] : 1'bz;
  end

  switch_box_cfg dut (
    .clk(clk), .rst_n(rst_n), .wtop(wtop), .wbottom(wbottom), .wleft(wleft), .wright(wright),
    .cfg_din(cfg_din), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_commit(cfg_commit),
    .cfg_abort(cfg_abort), .cfg_dout(cfg_dout), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );

  switch_box_cfg dut_b (
    .clk(clk), .rst_n(rst_n), .wtop(b_wtop), .wbottom(b_wbottom), .wleft(b_wleft), .wright(b_wright),
    .cfg_din(cfg_dout), .cfg_valid(b_valid), .cfg_ready(b_ready), .cfg_commit(b_commit),
    .cfg_abort(cfg_abort), .cfg_dout(b_dout), .cfg_done(b_done), .cfg_err(b_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;

  // Reference model state: entries as sent, expected drive mask, source positions, error flag.
  logic [5:0]       ent   [N_ENT];
  int               kind  [N_ENT];
  int               m_src [N_ENT];
  logic [N_ENT-1:0] m_en, m_en_b, old_en;
  logic             m_err, m_err_b, rdy_ok;
  logic [TOT-1:0]   strm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pos_of(input logic [2:0] side, input int idx);
    case (side)
      3'd1:    return idx;
      3'd3:    return NTB + idx;
      3'd4:    return 2*NTB + idx;
      default: return 2*NTB + NLR + idx;
    endcase
  endfunction

  function automatic logic [5:0] enc(input int p);
    if (p < NTB)              return {3'(p), 3'd1};
    else if (p < 2*NTB)       return {3'(p - NTB), 3'd3};
    else if (p < 2*NTB + NLR) return {3'(p - 2*NTB), 3'd4};
    else                      return {3'(p - 2*NTB - NLR), 3'd2};
  endfunction

  // Destinations only take sources that the DUT itself never drives, so routes never chain.
  task automatic gen_cfg(input bit allow_bad);
    for (int k = 0; k < N_ENT; k++) kind[k] = $urandom_range(0, allow_bad ? 3 : 2);
    for (int k = 0; k < N_ENT; k++) begin
      int p;
      case (kind[k])
        0: ent[k] = 6'd0;
        3: begin
          if ($urandom_range(0, 1) == 1) ent[k] = {3'($urandom), 3'($urandom_range(5, 7))};
          else if ($urandom_range(0, 1) == 1)
            ent[k] = {3'($urandom_range(NTB, 7)), (($urandom_range(0, 1) == 1) ? 3'd1 : 3'd3)};
          else
            ent[k] = {3'($urandom_range(NLR, 7)), (($urandom_range(0, 1) == 1) ? 3'd2 : 3'd4)};
        end
        default: begin
          p = -1;
          for (int t = 0; t < 40 && p < 0; t++) begin
            int q;
            q = $urandom_range(0, N_ENT - 1);
            if (kind[q] == 0 || kind[q] == 3) p = q;
          end
          ent[k] = (p < 0) ? 6'd0 : enc(p);
        end
      endcase
    end
  endtask

  task automatic model();
    m_err = 1'b0;
    m_en  = '0;
    for (int k = 0; k < N_ENT; k++) begin
      logic [2:0] side;
      int idx, lim;
      side = ent[k][2:0];
      idx  = int'(ent[k][5:3]);
      lim  = (side == 3'd1 || side == 3'd3) ? NTB : (side == 3'd2 || side == 3'd4) ? NLR : 0;
      m_src[k] = 0;
      if (side != 3'd0) begin
        if (side > 3'd4 || idx >= lim) m_err = 1'b1;
        else begin
          m_en[k]  = 1'b1;
          m_src[k] = pos_of(side, idx);
        end
      end
    end
    for (int k = 0; k < N_ENT; k++) strm[TOT-1-k*ENT_W -: ENT_W] = ent[k];
  endtask

  task automatic send_bit(input logic b);
    cfg_valid = 1'b1;
    cfg_din   = b;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_din   = 1'b0;
  endtask

  task automatic send_range(input int first, input int count);
    rdy_ok = 1'b1;
    for (int i = first; i < first + count; i++) begin
      if (cfg_ready !== 1'b1) rdy_ok = 1'b0;
      send_bit(strm[TOT-1-i]);
    end
  endtask

  task automatic do_commit(input string tag);
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    chk({tag, "_done_hi"}, cfg_done, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_done_lo"}, cfg_done, 1'b0);
  endtask

  task automatic check_routes(input string tag);
    tb_en = ~m_en;
    chk({tag, "_en"}, dut.drv_en, m_en);
    for (int r = 0; r < 2; r++) begin
      logic [N_ENT-1:0] exp;
      tb_val = N_ENT'($urandom);
      #1;
      exp = '0;
      for (int k = 0; k < N_ENT; k++) if (m_en[k]) exp[k] = tb_val[m_src[k]];
      chk({tag, "_val"}, wall & m_en, exp);
    end
  endtask

  task automatic load_commit(input string tag);
    tb_en = '0;
    send_range(0, TOT);
    chk({tag, "_rdy"}, rdy_ok, 1'b1);
    chk({tag, "_full"}, cfg_ready, 1'b0);
    do_commit(tag);
    chk({tag, "_err"}, cfg_err, m_err);
    check_routes(tag);
  endtask

  initial begin
    // Reset state and no routing.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_err", cfg_err, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_dout", cfg_dout, 1'b0);
    chk("rst_en", dut.drv_en, 18'd0);
    tb_en  = '1;
    tb_val = N_ENT'($urandom);
    #1;
    chk("rst_passthru", wall, tb_val);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", cfg_ready, 1'b1);

    // top[0] driven from right[2].
    for (int k = 0; k < N_ENT; k++) ent[k] = 6'd0;
    ent[0] = 6'b010_010;
    model();
    load_commit("t0r2");
    for (int v = 0; v < 2; v++) begin
      tb_val = N_ENT'($urandom);
      tb_val[2*NTB+NLR+2] = v[0];
      #1;
      chk("t0_follow", wtop[0], v[0]);
    end

    // Out-of-range index and invalid side both load as zero.
    for (int k = 0; k < N_ENT; k++) ent[k] = 6'd0;
    ent[2*NTB+1] = 6'b101_001;
    ent[NTB+4]   = 6'b000_110;
    model();
    load_commit("bad");
    chk("bad_err_set", cfg_err, 1'b1);
    gen_cfg(1'b0);
    model();
    load_commit("clean");
    chk("clean_err_clr", cfg_err, 1'b0);

    // Abort a partial load; active and err stay as they were.
    tb_en = '0;
    for (int i = 0; i < 50; i++) send_bit(1'($urandom));
    cfg_abort = 1'b1;
    cfg_valid = 1'b1;
    cfg_din   = 1'b1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    cfg_valid = 1'b0;
    cfg_din   = 1'b0;
    chk("abort_ready", cfg_ready, 1'b1);
    chk("abort_dout", cfg_dout, 1'b0);
    chk("abort_err", cfg_err, m_err);
    chk("abort_en", dut.drv_en, m_en);
    gen_cfg(1'b1);
    model();
    load_commit("post_abort");

    // Commit before the last bit is ignored; extra bits in FULL are refused.
    old_en = m_en;
    gen_cfg(1'b1);
    model();
    tb_en = '0;
    send_range(0, TOT - 1);
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
    chk("early_no_done", cfg_done, 1'b0);
    chk("early_ready", cfg_ready, 1'b1);
    chk("early_en_kept", dut.drv_en, old_en);
    send_range(TOT - 1, 1);
    chk("last_full", cfg_ready, 1'b0);
    chk("last_dout", cfg_dout, strm[TOT-1]);
    send_bit(~strm[TOT-1]);
    chk("full_ready", cfg_ready, 1'b0);
    chk("full_dout", cfg_dout, strm[TOT-1]);
    do_commit("late");
    chk("late_err", cfg_err, m_err);
    check_routes("late");

    // Random configurations.
    for (int n = 0; n < 5; n++) begin
      gen_cfg(1'b1);
      model();
      load_commit("rand");
    end

    // Daisy chain: box B's half travels through box A's shadow.
    gen_cfg(1'b1);
    model();
    m_en_b  = m_en;
    m_err_b = m_err;
    tb_en   = '0;
    send_range(0, TOT);
    do_commit("chain_p1");
    chk("chain_b_idle", b_ready, 1'b1);
    gen_cfg(1'b1);
    model();
    chain_en = 1'b1;
    send_range(0, TOT);
    chk("chain_rdy", rdy_ok, 1'b1);
    chk("chain_b_full", b_ready, 1'b0);
    do_commit("chain_p2");
    chk("chain_a_en", dut.drv_en, m_en);
    chk("chain_a_err", cfg_err, m_err);
    chk("chain_b_en", dut_b.drv_en, m_en_b);
    chk("chain_b_err", b_err, m_err_b);

    // Reset in the middle of a chained shift.
    gen_cfg(1'b0);
    model();
    send_range(0, 60);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst_a_en", dut.drv_en, 18'd0);
    chk("mrst_b_en", dut_b.drv_en, 18'd0);
    chk("mrst_ready", {cfg_ready, b_ready}, 2'b11);
    chk("mrst_err", {cfg_err, b_err}, 2'b00);
    chk("mrst_dout", {cfg_dout, b_dout}, 2'b00);
    chk("mrst_done", {cfg_done, b_done}, 2'b00);
    rst_n    = 1'b1;
    chain_en = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
